// File: rtl/scale_hfetch.sv
// Horizontal fetch front end of the bilinear scaler: walks a Q12.8 phase across one source line.
// Build option SCALE_HFETCH_EDGE_CLAMP_EN: edge pairs replicate the last pixel instead of emitting black.
`timescale 1ns/1ps
module scale_hfetch #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned W_BITS     = 12
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  line_start,
   input  logic [W_BITS-1:0]     src_w,
   input  logic [W_BITS-1:0]     dst_w,
   input  logic [15:0]           step,
   input  logic [7:0]            v_coff_a,
   input  logic [7:0]            v_coff_b,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] b,
   output logic [7:0]            a_coff,
   output logic [7:0]            b_coff,
   output logic [7:0]            a_coff_next,
   output logic [7:0]            b_coff_next,
   output logic                  data_en,
   output logic                  scale_en,
   output logic                  line_done
);

   localparam int unsigned POS_W = W_BITS + 8;
   localparam int unsigned CMP_W = W_BITS + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [W_BITS-1:0]     cnt_q, cnt_d;
   logic [W_BITS-1:0]     ocnt_q, ocnt_d;
   logic [W_BITS-1:0]     src_w_q, src_w_d;
   logic [W_BITS-1:0]     dst_w_q, dst_w_d;
   logic [15:0]           step_q, step_d;
   logic [DATA_WIDTH-1:0] w0_q, w0_d;
   logic [DATA_WIDTH-1:0] w1_q, w1_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [7:0]            a_coff_q, a_coff_d;
   logic [7:0]            b_coff_q, b_coff_d;
   logic [7:0]            a_coff_next_q, a_coff_next_d;
   logic [7:0]            b_coff_next_q, b_coff_next_d;
   logic                  data_en_q, data_en_d;
   logic                  scale_en_q, scale_en_d;
   logic                  line_done_q, line_done_d;
   logic                  in_ready_q, in_ready_d;

   logic [W_BITS-1:0]     idx;
   logic [W_BITS-1:0]     last_idx;
   logic                  accept;
   logic                  emit_int;
   logic                  emit_edge;
   logic                  emit;
   logic [DATA_WIDTH-1:0] edge_b;

   // Integer part of the phase, clamped to the last source pixel.
   function automatic logic [W_BITS-1:0] idx_fn(input logic [POS_W-1:0] p,
                                                 input logic [W_BITS-1:0] sw);
      logic [W_BITS-1:0] ip;
      logic [W_BITS-1:0] lst;
      ip  = p[POS_W-1:8];
      lst = sw - W_BITS'(1);
      return (ip > lst) ? lst : ip;
   endfunction

   // Ready is a pure function of state, so the registered copy is computed from next-state values.
   function automatic logic ready_fn(input state_e            st,
                                     input logic [W_BITS-1:0] c,
                                     input logic [POS_W-1:0]  p,
                                     input logic [W_BITS-1:0] sw);
      logic [W_BITS-1:0] ix;
      logic              rdy;
      ix  = idx_fn(p, sw);
      rdy = 1'b0;
      case (st)
         S_RUN:   rdy = (CMP_W'(c) < (CMP_W'(ix) + CMP_W'(2))) && (c < sw);
         S_DRAIN: rdy = (c < sw);
         default: rdy = 1'b0;
      endcase
      return rdy;
   endfunction

`ifdef SCALE_HFETCH_EDGE_CLAMP_EN
   assign edge_b = w1_q;
`else
   assign edge_b = '0;
`endif

   assign idx       = idx_fn(pos_q, src_w_q);
   assign last_idx  = src_w_q - W_BITS'(1);
   assign accept    = in_valid && in_ready_q;
   assign emit_int  = (CMP_W'(cnt_q) == (CMP_W'(idx) + CMP_W'(2)));
   assign emit_edge = (idx == last_idx) && (cnt_q == src_w_q);
   assign emit      = (state_q == S_RUN) && (emit_int || emit_edge);

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      pos_d         = pos_q;
      cnt_d         = cnt_q;
      ocnt_d        = ocnt_q;
      src_w_d       = src_w_q;
      dst_w_d       = dst_w_q;
      step_d        = step_q;
      w0_d          = w0_q;
      w1_d          = w1_q;
      a_d           = a_q;
      b_d           = b_q;
      a_coff_d      = a_coff_q;
      b_coff_d      = b_coff_q;
      a_coff_next_d = a_coff_next_q;
      b_coff_next_d = b_coff_next_q;
      data_en_d     = 1'b0;
      line_done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (line_start) begin
               src_w_d       = src_w;
               dst_w_d       = dst_w;
               step_d        = step;
               a_coff_next_d = v_coff_a;
               b_coff_next_d = v_coff_b;
               pos_d         = '0;
               cnt_d         = '0;
               ocnt_d        = '0;
               w0_d          = '0;
               w1_d          = '0;
               state_d       = (dst_w == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (emit) begin
               data_en_d = 1'b1;
               a_d       = emit_int ? w0_q : w1_q;
               b_d       = emit_int ? w1_q : edge_b;
               b_coff_d  = pos_q[7:0];
               a_coff_d  = 8'hff - pos_q[7:0];
               pos_d     = pos_q + POS_W'(step_q);
               ocnt_d    = ocnt_q + W_BITS'(1);
               if (ocnt_d == dst_w_q) begin
                  state_d = S_DRAIN;
               end
            end else if (accept) begin
               w0_d  = w1_q;
               w1_d  = in_data;
               cnt_d = cnt_q + W_BITS'(1);
            end
         end
         S_DRAIN: begin
            // Leftover pixels are consumed but never enter the window.
            if (accept) begin
               cnt_d = cnt_q + W_BITS'(1);
            end
            if (cnt_d == src_w_q) begin
               line_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      scale_en_d = emit || (scale_en_q && (state_q == S_RUN));
      in_ready_d = ready_fn(state_d, cnt_d, pos_d, src_w_d);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= S_IDLE;
         pos_q         <= '0;
         cnt_q         <= '0;
         ocnt_q        <= '0;
         src_w_q       <= '0;
         dst_w_q       <= '0;
         step_q        <= '0;
         w0_q          <= '0;
         w1_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         a_coff_q      <= '0;
         b_coff_q      <= '0;
         a_coff_next_q <= '0;
         b_coff_next_q <= '0;
         data_en_q     <= 1'b0;
         scale_en_q    <= 1'b0;
         line_done_q   <= 1'b0;
         in_ready_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pos_q         <= pos_d;
         cnt_q         <= cnt_d;
         ocnt_q        <= ocnt_d;
         src_w_q       <= src_w_d;
         dst_w_q       <= dst_w_d;
         step_q        <= step_d;
         w0_q          <= w0_d;
         w1_q          <= w1_d;
         a_q           <= a_d;
         b_q           <= b_d;
         a_coff_q      <= a_coff_d;
         b_coff_q      <= b_coff_d;
         a_coff_next_q <= a_coff_next_d;
         b_coff_next_q <= b_coff_next_d;
         data_en_q     <= data_en_d;
         scale_en_q    <= scale_en_d;
         line_done_q   <= line_done_d;
         in_ready_q    <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign a           = a_q;
   assign b           = b_q;
   assign a_coff      = a_coff_q;
   assign b_coff      = b_coff_q;
   assign a_coff_next = a_coff_next_q;
   assign b_coff_next = b_coff_next_q;
   assign data_en     = data_en_q;
   assign scale_en    = scale_en_q;
   assign line_done   = line_done_q;

endmodule

// File: tb/tb_scale_hfetch.sv
// Bench for scale_hfetch: closed-form pair model, per-cycle compare process, directed lines.
// Honours SCALE_HFETCH_EDGE_CLAMP_EN for the expected edge value.
`timescale 1ns/1ps
module tb_scale_hfetch;

`ifdef SCALE_HFETCH_EDGE_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        line_start = 1'b0;
   logic [11:0] src_w = '0;
   logic [11:0] dst_w = '0;
   logic [15:0] step = '0;
   logic [7:0]  v_coff_a = '0;
   logic [7:0]  v_coff_b = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a, b, a_coff, b_coff, a_coff_next, b_coff_next;
   logic        data_en, scale_en, line_done;

   scale_hfetch #(.DATA_WIDTH(8), .W_BITS(12)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .line_start(line_start),
      .src_w(src_w), .dst_w(dst_w), .step(step),
      .v_coff_a(v_coff_a), .v_coff_b(v_coff_b),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .a_coff(a_coff), .b_coff(b_coff),
      .a_coff_next(a_coff_next), .b_coff_next(b_coff_next),
      .data_en(data_en), .scale_en(scale_en), .line_done(line_done)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected line, written by the stimulus process only.
   logic [7:0] pix [16];
   logic [7:0] exp_a [64];
   logic [7:0] exp_b [64];
   logic [7:0] exp_ac [64];
   logic [7:0] exp_bc [64];
   int         exp_n = 0;
   int         exp_src = 0;
   logic [7:0] exp_vca = '0;
   logic [7:0] exp_vcb = '0;
   int         line_id = 0;

   // Destination pixel k samples source phase k*step directly.
   task automatic build(input int sw, input int dw, input logic [15:0] st);
      for (int k = 0; k < dw; k++) begin
         logic [19:0] p;
         int ip;
         int id;
         p  = 20'(k * int'(st));
         ip = int'(p[19:8]);
         id = (ip > sw - 1) ? sw - 1 : ip;
         exp_a[k]  = pix[id];
         exp_b[k]  = (id == sw - 1) ? (CLAMP ? pix[id] : 8'd0) : pix[id + 1];
         exp_bc[k] = p[7:0];
         exp_ac[k] = 8'hff - p[7:0];
      end
      exp_n   = dw;
      exp_src = sw;
   endtask

   // Compare process state, written by the compare process only.
   int         k_seen = 0;
   int         acc = 0;
   int         seen_id = 0;
   int         done_cnt = 0;
   logic [7:0] log_a [64];
   logic [7:0] log_b [64];
   logic [7:0] log_ac [64];
   logic [7:0] log_bc [64];
   int         log_id [64];

   initial begin
      forever begin
         @(negedge sys_clk);
         if (line_id != seen_id) begin
            seen_id = line_id;
            k_seen  = 0;
            acc     = 0;
         end
         if (in_valid && in_ready) acc++;
         chk("scale_en", 64'(scale_en),
             64'((k_seen > 0 && k_seen < exp_n) || (data_en && k_seen < exp_n)));
         if (data_en) begin
            chk("pair_in_range", 64'(k_seen < exp_n), 64'(1));
            if (k_seen < exp_n && k_seen < 64) begin
               chk("pair", 64'({a, b, a_coff, b_coff}),
                   64'({exp_a[k_seen], exp_b[k_seen], exp_ac[k_seen], exp_bc[k_seen]}));
               chk("coff_next_stable", 64'({a_coff_next, b_coff_next}), 64'({exp_vca, exp_vcb}));
               log_a[k_seen]  = a;
               log_b[k_seen]  = b;
               log_ac[k_seen] = a_coff;
               log_bc[k_seen] = b_coff;
               log_id[k_seen] = seen_id;
               k_seen++;
            end
         end
         if (line_done) begin
            chk("done_pairs", 64'(k_seen), 64'(exp_n));
            chk("done_accepts", 64'(acc), 64'(exp_src));
            done_cnt++;
         end
         // A reset sampled at the next edge kills the rest of the line.
         if (sys_rst) k_seen = exp_n;
      end
   end

   task automatic chk_log(input string nm, input int i,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input logic [7:0] eac, input logic [7:0] ebc);
      chk(nm, 64'({16'(log_id[i]), log_a[i], log_b[i], log_ac[i], log_bc[i]}),
          64'({16'(line_id), ea, eb, eac, ebc}));
   endtask

   task automatic feed(input int n, input bit tog);
      int  i = 0;
      int  cyc = 0;
      bit  took;
      while (i < n && cyc < 400) begin
         in_valid = tog ? (cyc % 2 == 0) : 1'b1;
         in_data  = pix[i];
         @(negedge sys_clk);
         took = in_valid && in_ready;
         @(posedge sys_clk); #1;
         if (took) i++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("feed_accepts", 64'(i), 64'(n));
   endtask

   task automatic wait_done(input int d0, input string nm);
      int c = 0;
      while (done_cnt == d0 && c < 300) begin
         @(posedge sys_clk); #1;
         c++;
      end
      chk({nm, "_line_done"}, 64'(done_cnt - d0), 64'(1));
      repeat (2) @(posedge sys_clk);
      #1;
   endtask

   task automatic run_line(input int sw, input int dw, input logic [15:0] st,
                           input logic [7:0] vca, input logic [7:0] vcb,
                           input bit tog, input int nfeed, input string nm);
      int d0;
      build(sw, dw, st);
      exp_vca = vca;
      exp_vcb = vcb;
      line_id++;
      d0 = done_cnt;
      line_start = 1'b1;
      src_w      = 12'(sw);
      dst_w      = 12'(dw);
      step       = st;
      v_coff_a   = vca;
      v_coff_b   = vcb;
      @(posedge sys_clk); #1;
      line_start = 1'b0;
      chk({nm, "_coff_next"}, 64'({a_coff_next, b_coff_next}), 64'({vca, vcb}));
      feed(nfeed, tog);
      if (nfeed == sw) wait_done(d0, nm);
   endtask

   task automatic chk_case1(input string nm);
      chk_log({nm, "_p0"}, 0, 8'd10, 8'd20, 8'hff, 8'h00);
      chk_log({nm, "_p1"}, 1, 8'd20, 8'd30, 8'hff, 8'h00);
      chk_log({nm, "_p2"}, 2, 8'd30, 8'd40, 8'hff, 8'h00);
      chk_log({nm, "_p3"}, 3, 8'd40, CLAMP ? 8'd40 : 8'd0, 8'hff, 8'h00);
   endtask

   task automatic load_case1();
      pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
   endtask

   initial begin
      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset_outputs", 64'({in_ready, a, b, a_coff, b_coff, a_coff_next, b_coff_next,
                                data_en, scale_en, line_done}), 64'(0));
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;

      load_case1();
      run_line(4, 4, 16'h0100, 8'h11, 8'h22, 1'b0, 4, "unity");
      chk_case1("unity");

      pix[0] = 8'd100; pix[1] = 8'd200;
      run_line(2, 4, 16'h0080, 8'h33, 8'h44, 1'b0, 2, "up2x");
      chk_log("up2x_p0", 0, 8'd100, 8'd200, 8'hff, 8'h00);
      chk_log("up2x_p1", 1, 8'd100, 8'd200, 8'h7f, 8'h80);
      chk_log("up2x_p2", 2, 8'd200, CLAMP ? 8'd200 : 8'd0, 8'hff, 8'h00);
      chk_log("up2x_p3", 3, 8'd200, CLAMP ? 8'd200 : 8'd0, 8'h7f, 8'h80);

      for (int i = 0; i < 8; i++) pix[i] = 8'(5 + 11 * i);
      run_line(8, 4, 16'h0200, 8'h55, 8'h66, 1'b0, 8, "down2x");
      chk_log("down2x_p0", 0, 8'd5, 8'd16, 8'hff, 8'h00);
      chk_log("down2x_p1", 1, 8'd27, 8'd38, 8'hff, 8'h00);
      chk_log("down2x_p2", 2, 8'd49, 8'd60, 8'hff, 8'h00);
      chk_log("down2x_p3", 3, 8'd71, 8'd82, 8'hff, 8'h00);

      load_case1();
      run_line(4, 4, 16'h0100, 8'h77, 8'h88, 1'b1, 4, "stall");
      chk_case1("stall");

      pix[0] = 8'd9; pix[1] = 8'd8; pix[2] = 8'd7;
      run_line(3, 0, 16'h0100, 8'h99, 8'haa, 1'b0, 3, "dst0");

      run_line(3, 3, 16'h0000, 8'h01, 8'h02, 1'b0, 3, "step0");
      chk_log("step0_p2", 2, 8'd9, 8'd8, 8'hff, 8'h00);

      for (int i = 0; i < 6; i++) pix[i] = 8'(200 - 13 * i);
      run_line(6, 4, 16'h0180, 8'h03, 8'h04, 1'b0, 6, "down1p5");
      run_line(3, 7, 16'h006e, 8'h05, 8'h06, 1'b1, 3, "upfrac");

      // Abort a line after its first pair, then replay it from scratch.
      load_case1();
      run_line(4, 4, 16'h0100, 8'h12, 8'h34, 1'b0, 2, "abort");
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      chk("abort_reset_outputs", 64'({in_ready, a, b, a_coff, b_coff, a_coff_next, b_coff_next,
                                      data_en, scale_en, line_done}), 64'(0));
      @(posedge sys_clk); #1;
      run_line(4, 4, 16'h0100, 8'h11, 8'h22, 1'b0, 4, "rerun");
      chk_case1("rerun");

      repeat (3) @(posedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
